// File: rtl/lsu_mem_if.sv
// Word-oriented data-memory bus between the load/store unit and data memory.
// The master issues requests with byte strobes, and the slave answers with ready and read data.
interface lsu_mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage of the mini-rv core: issues aligned loads/stores with byte strobes,
// extends load results and reports misalignment or memory timeouts back to control.
package instruction_utils;
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK, ILLEGAL
    } rv32i_instr_e;
endpackage

module load_store_unit
    import instruction_utils::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  rv32i_instr_e instr_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  store_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [31:0]  load_data_o,
    output logic         misaligned_o,
    output logic         timeout_o,
    lsu_mem_if.master    mem
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } state_e;

    state_e       state_q, state_d;
    rv32i_instr_e instr_q, instr_d;
    logic [1:0]   off_q, off_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [31:0]  load_data_q, load_data_d;
    logic         misaligned_q, misaligned_d;
    logic         timeout_q, timeout_d;
    logic         req_q, req_d;
    logic         we_q, we_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   wstrb_q, wstrb_d;

    logic        is_mem_op;
    logic        is_store;
    logic        is_misaligned;
    logic        timed_out;
    logic [31:0] store_wdata;
    logic [3:0]  store_wstrb;
    logic [31:0] shifted;
    logic [31:0] extended;

    // Decode of the incoming request, evaluated only when accepted in IDLE.
    always_comb begin
        is_mem_op     = instr_i inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
        is_store      = instr_i inside {SB, SH, SW};
        is_misaligned = ((instr_i inside {LH, LHU, SH}) && addr_i[0]) ||
                        ((instr_i inside {LW, SW}) && (addr_i[1:0] != 2'b00));
    end

    always_comb begin
        store_wdata = 32'h0;
        store_wstrb = 4'b0000;
        case (instr_i)
            SB: begin
                store_wdata = {4{store_data_i[7:0]}};
                store_wstrb = 4'b0001 << addr_i[1:0];
            end
            SH: begin
                store_wdata = {2{store_data_i[15:0]}};
                store_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            SW: begin
                store_wdata = store_data_i;
                store_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = mem.rdata >> {off_q, 3'b000};
        extended = shifted;
        case (instr_q)
            LB:      extended = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     extended = {24'h0, shifted[7:0]};
            LH:      extended = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     extended = {16'h0, shifted[15:0]};
            default: extended = shifted;
        endcase
    end

    // The counter value is the number of cycles already spent in the current state; aborting
    // when it is about to reach TIMEOUT_CYCLES caps the time in REQ or WAIT_R at that many cycles.
    assign timed_out = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        instr_d      = instr_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;
        timeout_d    = 1'b0;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        case (state_q)
            IDLE: begin
                if (start_i && is_mem_op) begin
                    instr_d = instr_i;
                    off_d   = addr_i[1:0];
                    if (is_misaligned) begin
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                        load_data_d  = 32'h0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 16'h0;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {addr_i[31:2], 2'b00};
                        wdata_d = store_wdata;
                        wstrb_d = store_wstrb;
                    end
                end
            end

            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (mem.ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                        cnt_d   = 16'h0;
                    end
                end else if (timed_out) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0;
                end
            end

            WAIT_R: begin
                cnt_d = cnt_q + 16'd1;
                if (mem.rvalid) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    load_data_d = extended;
                end else if (timed_out) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            instr_q      <= ILLEGAL;
            off_q        <= 2'b00;
            cnt_q        <= 16'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign load_data_o  = load_data_q;
    assign misaligned_o = misaligned_q;
    assign timeout_o    = timeout_q;
    assign mem.req      = req_q;
    assign mem.we       = we_q;
    assign mem.addr     = addr_q;
    assign mem.wdata    = wdata_q;
    assign mem.wstrb    = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, misalignment,
// timeout with a late rvalid, reset mid-load and back-to-back operation.
module tb_load_store_unit;
    import instruction_utils::*;

    logic         clk;
    logic         rst;
    logic         start;
    rv32i_instr_e instr;
    logic [31:0]  addr;
    logic [31:0]  store_data;
    logic         busy;
    logic         done;
    logic [31:0]  load_data;
    logic         misaligned;
    logic         timeout;

    int compared   = 0;
    int mismatched = 0;

    lsu_mem_if mem ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .instr_i      (instr),
        .addr_i       (addr),
        .store_data_i (store_data),
        .busy_o       (busy),
        .done_o       (done),
        .load_data_o  (load_data),
        .misaligned_o (misaligned),
        .timeout_o    (timeout),
        .mem          (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input rv32i_instr_e i, input logic [31:0] a, input logic [31:0] d);
        start      = 1'b1;
        instr      = i;
        addr       = a;
        store_data = d;
        step();
        start = 1'b0;
    endtask

    // Load with ready in the first REQ cycle and rvalid in the first WAIT_R cycle.
    task automatic do_load(input string tag, input rv32i_instr_e i, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        mem.ready = 1'b1;
        issue(i, a, 32'h0);
        check({tag, " req"}, {31'h0, mem.req}, 32'h1);
        check({tag, " addr"}, mem.addr, {a[31:2], 2'b00});
        check({tag, " wstrb"}, {28'h0, mem.wstrb}, 32'h0);
        step();
        mem.ready  = 1'b0;
        check({tag, " wait busy"}, {31'h0, busy}, 32'h1);
        mem.rvalid = 1'b1;
        mem.rdata  = rdata;
        step();
        mem.rvalid = 1'b0;
        check({tag, " done"}, {31'h0, done}, 32'h1);
        check({tag, " data"}, load_data, exp);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        instr      = ADD;
        addr       = 32'h0;
        store_data = 32'h0;
        mem.ready  = 1'b0;
        mem.rvalid = 1'b0;
        mem.rdata  = 32'h0;
        step();
        step();
        rst = 1'b0;
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst load_data", load_data, 32'h0);
        check("rst req", {31'h0, mem.req}, 32'h0);
        check("rst addr", mem.addr, 32'h0);
        check("rst wstrb", {28'h0, mem.wstrb}, 32'h0);

        // SW, ready in first REQ cycle: done two cycles after start
        mem.ready = 1'b1;
        issue(SW, 32'h0000_1004, 32'hDEAD_BEEF);
        check("sw req", {31'h0, mem.req}, 32'h1);
        check("sw we", {31'h0, mem.we}, 32'h1);
        check("sw addr", mem.addr, 32'h0000_1004);
        check("sw wstrb", {28'h0, mem.wstrb}, 32'hF);
        check("sw wdata", mem.wdata, 32'hDEAD_BEEF);
        check("sw busy", {31'h0, busy}, 32'h1);
        check("sw no early done", {31'h0, done}, 32'h0);
        step();
        mem.ready = 1'b0;
        check("sw done", {31'h0, done}, 32'h1);
        check("sw done busy", {31'h0, busy}, 32'h0);
        check("sw req drop", {31'h0, mem.req}, 32'h0);
        check("sw no flags", {30'h0, misaligned, timeout}, 32'h0);
        step();
        check("sw done pulse", {31'h0, done}, 32'h0);

        // SB with ready withheld 3 cycles; ready lands on the timeout edge and wins
        issue(SB, 32'h0000_2003, 32'h0000_00A5);
        check("sb addr", mem.addr, 32'h0000_2000);
        check("sb wstrb", {28'h0, mem.wstrb}, 32'h8);
        check("sb wdata", mem.wdata, 32'hA5A5_A5A5);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sb hold req", {31'h0, mem.req}, 32'h1);
            check("sb hold addr", mem.addr, 32'h0000_2000);
            check("sb hold wdata", mem.wdata, 32'hA5A5_A5A5);
            check("sb hold wstrb", {28'h0, mem.wstrb}, 32'h8);
            check("sb hold no done", {31'h0, done}, 32'h0);
        end
        mem.ready = 1'b1;
        step();
        mem.ready = 1'b0;
        check("sb done", {31'h0, done}, 32'h1);
        check("sb tie timeout", {31'h0, timeout}, 32'h0);

        // Loads with extension
        do_load("lb", LB, 32'h0000_3001, 32'h0000_F000, 32'hFFFF_FFF0);
        do_load("lbu", LBU, 32'h0000_3001, 32'h0000_F000, 32'h0000_00F0);
        do_load("lh", LH, 32'h0000_3002, 32'h8000_0000, 32'hFFFF_8000);
        do_load("lhu", LHU, 32'h0000_3002, 32'h8000_0000, 32'h0000_8000);
        do_load("lw", LW, 32'h0000_3000, 32'h1234_5678, 32'h1234_5678);

        // Misaligned LW and SH: one-cycle reject, no request
        issue(LW, 32'h0000_4002, 32'h0);
        check("mis lw done", {31'h0, done}, 32'h1);
        check("mis lw flag", {31'h0, misaligned}, 32'h1);
        check("mis lw data", load_data, 32'h0);
        check("mis lw req", {31'h0, mem.req}, 32'h0);
        check("mis lw busy", {31'h0, busy}, 32'h0);
        step();
        check("mis flag clears", {31'h0, misaligned}, 32'h0);
        issue(SH, 32'h0000_5001, 32'h1111_2222);
        check("mis sh flag", {31'h0, misaligned}, 32'h1);
        check("mis sh req", {31'h0, mem.req}, 32'h0);

        // Non-memory instruction ignored
        issue(ADD, 32'h0000_5000, 32'h0);
        check("ignore done", {31'h0, done}, 32'h0);
        check("ignore busy", {31'h0, busy}, 32'h0);

        // Timeout in WAIT_R after 4 cycles; start while busy and a late rvalid are ignored
        do_load("pre", LW, 32'h0000_6000, 32'h0BAD_F00D, 32'h0BAD_F00D);
        mem.ready = 1'b1;
        issue(LW, 32'h0000_6000, 32'h0);
        step();
        mem.ready = 1'b0;
        check("to wait1 busy", {31'h0, busy}, 32'h1);
        issue(SW, 32'h0000_9000, 32'h5555_5555);
        check("to wait2 done", {31'h0, done}, 32'h0);
        step();
        check("to ignore start", mem.addr, 32'h0000_6000);
        check("to wait3 done", {31'h0, done}, 32'h0);
        step();
        check("to wait4 done", {31'h0, done}, 32'h0);
        check("to wait4 busy", {31'h0, busy}, 32'h1);
        step();
        check("to done", {31'h0, done}, 32'h1);
        check("to flag", {31'h0, timeout}, 32'h1);
        check("to data", load_data, 32'h0);
        check("to req", {31'h0, mem.req}, 32'h0);
        check("to busy", {31'h0, busy}, 32'h0);
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h7777_7777;
        step();
        mem.rvalid = 1'b0;
        check("late rvalid done", {31'h0, done}, 32'h0);
        check("late rvalid data", load_data, 32'h0);

        // Reset while in WAIT_R
        mem.ready = 1'b1;
        issue(LW, 32'h0000_7000, 32'h0);
        step();
        mem.ready = 1'b0;
        check("rst mid busy before", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mid busy", {31'h0, busy}, 32'h0);
        check("rst mid done", {31'h0, done}, 32'h0);
        check("rst mid addr", mem.addr, 32'h0);
        check("rst mid req", {31'h0, mem.req}, 32'h0);
        mem.rvalid = 1'b1;
        mem.rdata  = 32'h1357_9BDF;
        step();
        mem.rvalid = 1'b0;
        check("rst late rvalid done", {31'h0, done}, 32'h0);
        check("rst late rvalid data", load_data, 32'h0);

        // Back-to-back: store issued in the load's done cycle
        do_load("b2b", LW, 32'h0000_8000, 32'hCAFE_F00D, 32'hCAFE_F00D);
        mem.ready = 1'b1;
        issue(SH, 32'h0000_8006, 32'h1234_ABCD);
        check("b2b sh req", {31'h0, mem.req}, 32'h1);
        check("b2b sh addr", mem.addr, 32'h0000_8004);
        check("b2b sh wstrb", {28'h0, mem.wstrb}, 32'hC);
        check("b2b sh wdata", mem.wdata, 32'hABCD_ABCD);
        step();
        mem.ready = 1'b0;
        check("b2b sh done", {31'h0, done}, 32'h1);
        check("b2b load_data held", load_data, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
